// File: rtl/vga_pixel_generator_if.sv
// Bundle between the VGA sync controller and the pixel generator: the sync
// strobes travel in, the coloured pixel stream and its metadata come back out.
interface vga_pixel_generator_if #(
  parameter int unsigned COUNTER_SIZE = 11,
  parameter int unsigned COLOR_WIDTH  = 4
);
  logic                    h_sync;
  logic                    v_sync;
  logic [COLOR_WIDTH-1:0]  red;
  logic [COLOR_WIDTH-1:0]  green;
  logic [COLOR_WIDTH-1:0]  blue;
  logic                    display_enable;
  logic                    h_sync_out;
  logic                    v_sync_out;
  logic [COUNTER_SIZE-1:0] pixel_x;
  logic [COUNTER_SIZE-1:0] pixel_y;
  logic                    frame_start;
  logic                    line_overrun;

  modport master (
    output h_sync, v_sync,
    input  red, green, blue, display_enable, h_sync_out, v_sync_out,
           pixel_x, pixel_y, frame_start, line_overrun
  );

  modport slave (
    input  h_sync, v_sync,
    output red, green, blue, display_enable, h_sync_out, v_sync_out,
           pixel_x, pixel_y, frame_start, line_overrun
  );
endinterface

// File: rtl/vga_pixel_generator.sv
// Two-stage pixel generator: coordinates and an 8-bar colour pattern derived from
// the sync strobes. Define VGA_BORDER_EN to paint a white one-pixel frame border.
module vga_pixel_generator #(
  parameter int unsigned               COUNTER_SIZE = 11,
  parameter int unsigned               COLOR_WIDTH  = 4,
  parameter logic [COUNTER_SIZE-1:0]   H_ACTIVE     = 11'd1024,
  parameter logic [COUNTER_SIZE-1:0]   V_ACTIVE     = 11'd768,
  parameter logic [COUNTER_SIZE-1:0]   BAR_WIDTH    = 11'd128
) (
  input  logic                 control_clock,
  input  logic                 reset,
  vga_pixel_generator_if.slave bus
);

  localparam logic [COUNTER_SIZE-1:0] ONE      = COUNTER_SIZE'(1);
  localparam logic [COUNTER_SIZE-1:0] H_LAST   = H_ACTIVE - ONE;
  localparam logic [COUNTER_SIZE-1:0] V_LAST   = V_ACTIVE - ONE;
  localparam logic [COUNTER_SIZE-1:0] BAR_LAST = BAR_WIDTH - ONE;

  logic                    r_h_d;
  logic                    r_v_d;
  logic [COUNTER_SIZE-1:0] r_px;
  logic [COUNTER_SIZE-1:0] r_py;
  logic [COUNTER_SIZE-1:0] r_bar_cnt;
  logic [2:0]              r_bar_idx;
  logic                    r_de1;
  logic                    r_fs1;
  logic                    r_frame_pend;
  logic                    r_over;

  logic [COLOR_WIDTH-1:0]  r_red;
  logic [COLOR_WIDTH-1:0]  r_green;
  logic [COLOR_WIDTH-1:0]  r_blue;
  logic                    r_de2;
  logic                    r_hso;
  logic                    r_vso;
  logic [COUNTER_SIZE-1:0] r_pixel_x;
  logic [COUNTER_SIZE-1:0] r_pixel_y;
  logic                    r_fs2;
  logic                    r_over2;

  logic                    w_h_rise;
  logic                    w_h_fall;
  logic                    w_v_rise;
  logic                    w_line_long;
  logic                    w_frame_long;
  logic [COLOR_WIDTH-1:0]  w_red;
  logic [COLOR_WIDTH-1:0]  w_green;
  logic [COLOR_WIDTH-1:0]  w_blue;

  assign w_h_rise = bus.h_sync & ~r_h_d;
  assign w_h_fall = ~bus.h_sync & r_h_d;
  assign w_v_rise = bus.v_sync & ~r_v_d;

  // A frame is too long if the last line ended and another line starts without v_sync restarting.
  assign w_line_long  = bus.h_sync & ~w_h_rise & (r_px == H_LAST);
  assign w_frame_long = w_h_rise & bus.v_sync & r_frame_pend & ~w_v_rise;

  always_ff @(posedge control_clock or posedge reset) begin
    if (reset) begin
      r_h_d        <= 1'b0;
      r_v_d        <= 1'b0;
      r_px         <= '0;
      r_py         <= '0;
      r_bar_cnt    <= '0;
      r_bar_idx    <= '0;
      r_de1        <= 1'b0;
      r_fs1        <= 1'b0;
      r_frame_pend <= 1'b0;
      r_over       <= 1'b0;
    end else begin
      r_h_d <= bus.h_sync;
      r_v_d <= bus.v_sync;

      if (w_h_rise)
        r_px <= '0;
      else if (bus.h_sync && (r_px != H_LAST))
        r_px <= r_px + ONE;

      // Bar counter advances in lockstep with px so the bar index freezes once px saturates.
      if (w_h_rise) begin
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
      end else if (bus.h_sync && (r_px < H_LAST)) begin
        if (r_bar_cnt == BAR_LAST) begin
          r_bar_cnt <= '0;
          r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_cnt <= r_bar_cnt + ONE;
        end
      end

      if (w_v_rise)
        r_py <= '0;
      else if (w_h_fall && bus.v_sync && (r_py != V_LAST))
        r_py <= r_py + ONE;

      r_de1 <= bus.h_sync & bus.v_sync;
      r_fs1 <= w_h_rise & bus.v_sync & ((r_py == '0) | w_v_rise);

      if (!bus.v_sync || w_v_rise)
        r_frame_pend <= 1'b0;
      else if (w_h_fall && (r_py == V_LAST))
        r_frame_pend <= 1'b1;

      if (w_line_long || w_frame_long)
        r_over <= 1'b1;
    end
  end

  always_comb begin
    w_red   = {COLOR_WIDTH{r_bar_idx[2] & r_de1}};
    w_green = {COLOR_WIDTH{r_bar_idx[1] & r_de1}};
    w_blue  = {COLOR_WIDTH{r_bar_idx[0] & r_de1}};
`ifdef VGA_BORDER_EN
    if (r_de1 && ((r_px == '0) || (r_px == H_LAST) || (r_py == '0) || (r_py == V_LAST))) begin
      w_red   = '1;
      w_green = '1;
      w_blue  = '1;
    end
`endif
  end

  // Second stage keeps every output, including the overrun flag, on the same t+2 timing.
  always_ff @(posedge control_clock or posedge reset) begin
    if (reset) begin
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
      r_de2     <= 1'b0;
      r_hso     <= 1'b0;
      r_vso     <= 1'b0;
      r_pixel_x <= '0;
      r_pixel_y <= '0;
      r_fs2     <= 1'b0;
      r_over2   <= 1'b0;
    end else begin
      r_red     <= w_red;
      r_green   <= w_green;
      r_blue    <= w_blue;
      r_de2     <= r_de1;
      r_hso     <= r_h_d;
      r_vso     <= r_v_d;
      r_pixel_x <= r_px;
      r_pixel_y <= r_py;
      r_fs2     <= r_fs1;
      r_over2   <= r_over;
    end
  end

  assign bus.red            = r_red;
  assign bus.green          = r_green;
  assign bus.blue           = r_blue;
  assign bus.display_enable = r_de2;
  assign bus.h_sync_out     = r_hso;
  assign bus.v_sync_out     = r_vso;
  assign bus.pixel_x        = r_pixel_x;
  assign bus.pixel_y        = r_pixel_y;
  assign bus.frame_start    = r_fs2;
  assign bus.line_overrun   = r_over2;

endmodule
